// File: rtl/seq_booth_mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state type,
// default operand width and the derived counter width.
package Parameter_Definitions;

    localparam int NBITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must hold NBITS, so it needs clog2(NBITS+1) bits.
    function automatic int cnt_width(input int nbits);
        return (nbits < 1) ? 1 : $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/seq_booth_mult_if.sv
// Request/result bundle of the sequential Booth multiplier.
// The master issues operands with start; the slave returns product and status.
interface seq_booth_mult_if #(
    parameter int NBITS = Parameter_Definitions::NBITS_DEFAULT
);
    logic                   start;
    logic                   signed_mode;
    logic [NBITS-1:0]       multiplicand;
    logic [NBITS-1:0]       multiplier;
    logic [2*NBITS-1:0]     product;
    logic                   ready;
    logic                   busy;
    logic                   done;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  product, ready, busy, done
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output product, ready, busy, done
    );
endinterface

// File: rtl/seq_booth_mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of A into the high
// half, then an arithmetic right shift of {acc, Q, Q[-1]}.
module booth_step #(
    parameter int W  = 10,  // accumulator / adder width
    parameter int QW = 9    // multiplier register width
) (
    input  logic [W-1:0]  acc,
    input  logic [W-1:0]  a_ext,
    input  logic [QW-1:0] q,
    input  logic          q_m1,
    output logic [W-1:0]  acc_next,
    output logic [QW-1:0] q_next,
    output logic          q_m1_next
);

    logic [W-1:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b10:   sum = acc - a_ext;
            2'b01:   sum = acc + a_ext;
            default: sum = acc;
        endcase
    end

    // Arithmetic shift: the sign of the sum is replicated, its LSB moves into Q.
    assign acc_next[W-1] = sum[W-1];
    generate
        for (genvar gi = 0; gi < W - 1; gi++) begin : g_acc_shift
            assign acc_next[gi] = sum[gi+1];
        end
    endgenerate

    assign q_next[QW-1] = sum[0];
    generate
        for (genvar gi = 0; gi < QW - 1; gi++) begin : g_q_shift
            assign q_next[gi] = q[gi+1];
        end
    endgenerate

    assign q_m1_next = q[0];

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier: one step per clock over NBITS+1
// extended operands, signed or unsigned, result held in a register.
module seq_booth_mult #(
    parameter int NBITS = Parameter_Definitions::NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    seq_booth_mult_if.slave  bus
);
    import Parameter_Definitions::*;

    localparam int OW = NBITS + 1;        // extended operand width
    localparam int AW = NBITS + 2;        // adder width, keeps -A from wrapping
    localparam int CW = cnt_width(NBITS);
    localparam int PW = 2 * NBITS;

    localparam logic [1:0]    ST_IDLE  = 2'(IDLE);
    localparam logic [1:0]    ST_CALC  = 2'(CALC);
    localparam logic [1:0]    ST_DONE  = 2'(DONE);
    localparam logic [CW-1:0] CNT_LOAD = CW'(NBITS);

    logic [1:0]    state_reg, state_next;
    logic [OW-1:0] a_reg;
    logic [OW-1:0] q_reg;
    logic          q_m1_reg;
    logic [AW-1:0] acc_reg;
    logic [CW-1:0] cnt_reg;
    logic [PW-1:0] product_reg;

    logic [OW-1:0] a_in_ext;
    logic [OW-1:0] b_in_ext;
    logic [AW-1:0] a_adder;
    logic [AW-1:0] step_acc;
    logic [OW-1:0] step_q;
    logic          step_q_m1;
    logic          last_step;

    // Zero- or sign-extension decided by the mode presented with start.
    assign a_in_ext = bus.signed_mode ? {bus.multiplicand[NBITS-1], bus.multiplicand}
                                      : {1'b0, bus.multiplicand};
    assign b_in_ext = bus.signed_mode ? {bus.multiplier[NBITS-1], bus.multiplier}
                                      : {1'b0, bus.multiplier};

    assign a_adder   = {a_reg[OW-1], a_reg};
    assign last_step = (cnt_reg == '0);

    booth_step #(
        .W  (AW),
        .QW (OW)
    ) u_booth_step (
        .acc       (acc_reg),
        .a_ext     (a_adder),
        .q         (q_reg),
        .q_m1      (q_m1_reg),
        .acc_next  (step_acc),
        .q_next    (step_q),
        .q_m1_next (step_q_m1)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.start) state_next = ST_CALC;
            ST_CALC: if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            q_m1_reg    <= 1'b0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg    <= a_in_ext;
                        q_reg    <= b_in_ext;
                        q_m1_reg <= 1'b0;
                        acc_reg  <= '0;
                        cnt_reg  <= CNT_LOAD;
                    end
                end
                ST_CALC: begin
                    acc_reg  <= step_acc;
                    q_reg    <= step_q;
                    q_m1_reg <= step_q_m1;
                    // The low 2*NBITS bits of {acc, Q} after the final shift.
                    if (last_step) begin
                        product_reg <= {step_acc[NBITS-2:0], step_q};
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.product = product_reg;
    assign bus.ready   = (state_reg == ST_IDLE);
    assign bus.busy    = (state_reg == ST_CALC);
    assign bus.done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_seq_booth_mult.sv
// Bench for seq_booth_mult: fixed vectors, overlap and reset corner cases,
// random 8-bit operations and an exhaustive 4-bit sweep against plain arithmetic.
module tb_seq_booth_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_booth_mult_if #(.NBITS(8)) bus8();
    seq_booth_mult_if #(.NBITS(4)) bus4();

    seq_booth_mult #(.NBITS(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    seq_booth_mult #(.NBITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Exact product of two n-bit operands, truncated to 2n bits.
    function automatic logic [63:0] ref_mult(input int n, input bit sm,
                                             input logic [31:0] a, input logic [31:0] b);
        longint mask;
        longint sa;
        longint sb;
        longint p;
        mask = (longint'(1) << n) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sm && sa[n-1]) sa = sa - (longint'(1) << n);
        if (sm && sb[n-1]) sb = sb - (longint'(1) << n);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * n)) - 64'd1);
    endfunction

    function automatic logic get_done(input int n);
        return (n == 8) ? bus8.done : bus4.done;
    endfunction
    function automatic logic get_busy(input int n);
        return (n == 8) ? bus8.busy : bus4.busy;
    endfunction
    function automatic logic get_ready(input int n);
        return (n == 8) ? bus8.ready : bus4.ready;
    endfunction
    function automatic logic [63:0] get_product(input int n);
        return (n == 8) ? 64'(bus8.product) : 64'(bus4.product);
    endfunction

    task automatic drive(input int n, input logic st, input logic sm,
                         input logic [31:0] a, input logic [31:0] b);
        if (n == 8) begin
            bus8.start = st; bus8.signed_mode = sm;
            bus8.multiplicand = a[7:0]; bus8.multiplier = b[7:0];
        end else begin
            bus4.start = st; bus4.signed_mode = sm;
            bus4.multiplicand = a[3:0]; bus4.multiplier = b[3:0];
        end
    endtask

    // One full operation with timing checks; operands are scrambled after accept.
    task automatic run_op(input int n, input bit sm, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] prod);
        int lat;
        bit busy_ok;
        @(negedge clk);
        drive(n, 1'b1, sm, a, b);
        @(posedge clk); #1;
        chk("busy_after_accept", 64'(get_busy(n)), 64'd1);
        @(negedge clk);
        drive(n, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (get_done(n)) break;
            if (!get_busy(n)) busy_ok = 1'b0;
        end
        chk("done_latency", 64'(lat), 64'(n + 1));
        chk("busy_through_calc", 64'(busy_ok), 64'd1);
        chk("busy_low_in_done", 64'(get_busy(n)), 64'd0);
        prod = get_product(n);
        @(posedge clk); #1;
        chk("done_single_cycle", 64'(get_done(n)), 64'd0);
        chk("ready_after_done", 64'(get_ready(n)), 64'd1);
    endtask

    initial begin
        logic [63:0] prod;
        logic [63:0] exp;
        int dones;
        int done_cyc;
        bit saw_done;

        tbl[0] = '{1'b1, 8'hFD, 8'hFE, 16'h0006};
        tbl[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        tbl[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tbl[4] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        tbl[5] = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};
        tbl[6] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        tbl[7] = '{1'b0, 8'h00, 8'hFF, 16'h0000};
        tbl[8] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        tbl[9] = '{1'b0, 8'h0C, 8'h0A, 16'h0078};

        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset_ready8", 64'(bus8.ready), 64'd1);
        chk("reset_busy8", 64'(bus8.busy), 64'd0);
        chk("reset_done8", 64'(bus8.done), 64'd0);
        chk("reset_product8", 64'(bus8.product), 64'd0);
        chk("reset_ready4", 64'(bus4.ready), 64'd1);
        chk("reset_product4", 64'(bus4.product), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            run_op(8, tbl[i].sm, 32'(tbl[i].a), 32'(tbl[i].b), prod);
            $display("vec %0d sm=%0d a=%h b=%h product=%h expected=%h",
                     i, tbl[i].sm, tbl[i].a, tbl[i].b, prod[15:0], tbl[i].exp);
            chk("vector_product", prod, 64'(tbl[i].exp));
        end

        // A second start during CALC/DONE must not re-latch or queue.
        @(negedge clk);
        drive(8, 1'b1, 1'b1, 32'd5, 32'd7);
        @(posedge clk);
        dones = 0;
        done_cyc = -1;
        prod = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc >= 3 && cyc <= 5) drive(8, 1'b1, 1'b1, 32'd4, 32'd4);
            else                      drive(8, 1'b0, 1'b1, 32'd4, 32'd4);
            @(posedge clk); #1;
            if (bus8.done) begin
                dones++;
                done_cyc = cyc;
                prod = 64'(bus8.product);
            end
        end
        $display("overlap dones=%0d at_cycle=%0d product=%h", dones, done_cyc, prod[15:0]);
        chk("overlap_done_count", 64'(dones), 64'd1);
        chk("overlap_done_cycle", 64'(done_cyc), 64'd9);
        chk("overlap_product", prod, 64'h0023);
        chk("overlap_ready", 64'(bus8.ready), 64'd1);

        // Reset in the fourth CALC cycle aborts without a done pulse.
        @(negedge clk);
        drive(8, 1'b1, 1'b1, 32'h55, 32'h33);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_ready", 64'(bus8.ready), 64'd1);
        chk("abort_busy", 64'(bus8.busy), 64'd0);
        chk("abort_product", 64'(bus8.product), 64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus8.done) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        run_op(8, 1'b1, 32'hFE, 32'h03, prod);
        $display("post_reset sm=1 a=fe b=03 product=%h expected=fffa", prod[15:0]);
        chk("post_reset_product", prod, 64'hFFFA);

        for (int i = 0; i < 60; i++) begin
            bit sm;
            logic [31:0] a;
            logic [31:0] b;
            sm = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(0, 255));
            run_op(8, sm, a, b, prod);
            exp = ref_mult(8, sm, a, b);
            $display("rand %0d sm=%0d a=%h b=%h product=%h expected=%h",
                     i, sm, a[7:0], b[7:0], prod[15:0], exp[15:0]);
            chk("random_product", prod, exp);
        end

        for (int sm = 0; sm < 2; sm++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run_op(4, 1'(sm), 32'(a), 32'(b), prod);
                    exp = ref_mult(4, 1'(sm), 32'(a), 32'(b));
                    $display("sweep4 sm=%0d a=%h b=%h product=%h expected=%h",
                             sm, a[3:0], b[3:0], prod[7:0], exp[7:0]);
                    chk("sweep4_product", prod, exp);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_booth_mult.md
SEQ_BOOTH_MULT -- requirements
Module: seq_booth_mult

Interface
REQ-001 Parameter NBITS, default 8: operand width, legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  synchronous request; sampled only in IDLE.
REQ-005 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 multiplicand  input  NBITS  operand A; sampled with start.
REQ-007 multiplier  input  NBITS  operand B; sampled with start.
REQ-008 product  output  2*NBITS  registered result; held until the next accepted start or reset.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high only in CALC.
REQ-011 done  output  1  one-cycle pulse in DONE; product is valid in that cycle.

Function
REQ-012 States: IDLE, CALC, DONE. No other states are reachable; any illegal encoding SHALL return to IDLE.
REQ-013 IDLE -> CALC on the edge where start=1. That edge latches the operands and signed_mode, clears the accumulator and loads the iteration counter with NBITS.
REQ-014 Operands SHALL be extended to NBITS+1 bits: sign-extended when signed_mode=1, zero-extended when 0.
REQ-015 CALC performs one radix-2 Booth step per cycle on the pair (Q[0], Q[-1]):
  - 10: subtract A from the high half.
  - 01: add A to the high half.
  - 00 or 11: no add/subtract.
  - Every step ends with an arithmetic right shift of {acc, Q, Q[-1]}.
REQ-016 CALC lasts exactly NBITS+1 cycles; the counter decrements once per step.
REQ-017 CALC -> DONE after the step taken with counter=0. product loads the low 2*NBITS bits of the (2*NBITS+2)-bit result on that same edge.
REQ-018 DONE -> IDLE unconditionally after one cycle.
REQ-019 Latency: if start is accepted at edge k, done=1 in the cycle following edge k+NBITS+1; the next start can be accepted at edge k+NBITS+3.
REQ-020 start in CALC or DONE SHALL be ignored: no operand re-latch, no restart, no queuing.
REQ-021 Operand inputs SHALL NOT affect an operation in progress after the accept edge.
REQ-022 The result SHALL be exact for every operand pair in both modes; no overflow flag exists.
  - Boundary: signed -2^(NBITS-1) x -2^(NBITS-1) = +2^(2*NBITS-2).
  - Boundary: unsigned (2^NBITS-1)^2.
REQ-023 The internal adder SHALL be NBITS+2 bits wide so the subtract of the most negative operand does not wrap.

Reset
REQ-024 While rst=0: state=IDLE; product, accumulator, operand registers and counter = 0; ready=1, busy=0, done=0.
REQ-025 Reset asserted mid-CALC or in DONE aborts the operation. No done pulse is produced; product=0.
REQ-026 After rst deasserts, the first start may be accepted on the first rising edge.

Structure
REQ-027 Shared package Parameter_Definitions SHALL hold:
  - the state enum typedef (IDLE, CALC, DONE);
  - the default NBITS constant.
REQ-028 Counter width SHALL be $clog2(NBITS+1) bits, derived from NBITS.
REQ-029 One sub-module, booth_step: a combinational Booth add/subtract-and-shift datapath over NBITS+2 bits, instantiated once. The FSM, counter and registers stay in seq_booth_mult.
REQ-030 All outputs SHALL be driven from registers or decoded from the state register only; no input-to-output combinational path.

Verification
REQ-031 NBITS=8, signed_mode=1, A=-3, B=-2, start pulse -> busy for 9 cycles, then done with product=16'h0006.
REQ-032 NBITS=8, signed_mode=0, A=8'hFF, B=8'hFF -> product=16'hFE01. Same operands with signed_mode=1 -> product=16'h0001.
REQ-033 NBITS=8, signed_mode=1, A=-128, B=-128 -> product=16'h4000. Then A=-128, B=127 -> product=16'hC080.
REQ-034 Start at cycle k with A=5, B=7; re-pulse start with A=4, B=4 at k+3 -> exactly one done pulse, product=16'h0023; ready returns after DONE.
REQ-035 rst pulled low at cycle 4 of CALC -> ready=1, product=0, no done pulse. The next start with A=-2, B=3 -> product=16'hFFFA.
REQ-036 NBITS=4: exhaustive sweep of all 256 operand pairs in both modes against a reference model. Check done timing per REQ-019 on every operation.
